wb_write_queue: RTL
===================

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 Parameter AW, default 5, register address width.
REQ-003 Parameter DW, default 32, register data width.
REQ-004 Single clock, clk; reset is synchronous and active-high, named Reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 Reset  in  1  synchronous active-high reset.
REQ-007 In_Valid  in  1  upstream write request valid.
REQ-008 In_Ready  out  1  queue can accept a request.
REQ-009 In_Addr  in  AW  destination register number.
REQ-010 In_Data  in  DW  value to write.
REQ-011 Drain_En  in  1  permits write-back to the register file this cycle.
REQ-012 Write_Reg  out  1  register-file write enable.
REQ-013 W_Addr  out  AW  register-file write address (head entry).
REQ-014 W_Data  out  DW  register-file write data (head entry).
REQ-015 Q_Addr  in  AW  forwarding lookup address.
REQ-016 Q_Hit  out  1  a queued write targets Q_Addr.
REQ-017 Q_Data  out  DW  youngest queued data for Q_Addr.
REQ-018 Count  out  log2(DEPTH)+1  occupied entries.
REQ-019 Empty, Full  out  1 each  Count==0, Count==DEPTH.

Function
REQ-020 Push occurs on a clk edge when In_Valid && In_Ready; the entry {In_Addr, In_Data} is stored at the tail.
REQ-021 In_Ready SHALL equal !Full; a push is not accepted when full, even if a pop happens in the same cycle.
REQ-022 Write_Reg SHALL equal !Empty && Drain_En (combinational); W_Addr/W_Data SHALL always present the head entry.
REQ-023 Pop occurs on the clk edge on which Write_Reg==1; the head advances one entry.
REQ-024 Minimum latency: a request pushed at edge N is presented on Write_Reg in the cycle after edge N. There is no same-cycle pass-through.
REQ-025 Simultaneous push and pop leaves Count unchanged; both pointers advance.
REQ-026 Head and tail pointers wrap modulo DEPTH; FIFO order is preserved across the wrap.
REQ-027 Q_Hit SHALL be 1 if any occupied entry's address equals Q_Addr, including the head being popped this cycle.
REQ-028 Q_Data SHALL be the data of the youngest matching entry, or 0 when Q_Hit==0; combinational from the stored state.
REQ-029 Register address 0 has no special treatment; it is queued and forwarded like any other address.
REQ-030 Drain_En==0 freezes popping only; pushes continue until Full.
REQ-031 Count, Empty and Full reflect registered state only; they change only at clk edges.

Reset
REQ-032 When Reset==1 at a clk edge, head, tail and Count SHALL clear to 0 and all entry storage SHALL clear to 0.
REQ-033 Reset overrides any push or pop in the same cycle; the in-flight request is dropped.
REQ-034 After reset: Empty=1, Full=0, In_Ready=1, Write_Reg=0, W_Addr=0, W_Data=0, Q_Hit=0, Q_Data=0.

Structure
REQ-035 A shared package SHALL hold DEPTH, AW and DW defaults, the pointer-width constant, and the entry typedef {addr, data}.
REQ-036 Youngest-match selection SHALL be a sub-module wbq_match: occupancy mask, addresses, data and tail in; hit and data out; purely combinational.
REQ-037 Storage SHALL be a flat register array with no RAM macro.

Verification
REQ-038 Three pushes with Drain_En=1: (3,0xA), (7,0xB), (3,0xC) -> writes (3,0xA), (7,0xB), (3,0xC) on consecutive cycles, each starting one cycle after its push.
REQ-039 Drain_En=0 while pushing 5 entries with DEPTH=4 -> In_Ready=0 after the 4th push, the 5th is held by upstream, Full=1, Count=4, Write_Reg=0.
REQ-040 Queue holds (3,0x11), (5,0x22), (3,0x33) and Q_Addr=3 -> Q_Hit=1, Q_Data=0x33; Q_Addr=9 -> Q_Hit=0, Q_Data=0.
REQ-041 Count=2 with push and pop on the same edge -> Count stays 2; after 10 sustained push/pop cycles the output order matches input order across pointer wrap.
REQ-042 Reset asserted with Count=3 and a push pending -> next cycle Count=0, Empty=1, Write_Reg=0, W_Addr=0, W_Data=0, and the pending push is lost.

Source files
------------

// File: rtl/wb_write_queue_pkg.sv
// Shared constants and types for the register write-back queue.
// Holds the default geometry (depth, address width, data width), the
// pointer width derived from the default depth, and the queue entry type.
package wb_write_queue_pkg;

    localparam int unsigned WBQ_DEPTH = 4;
    localparam int unsigned WBQ_AW    = 5;
    localparam int unsigned WBQ_DW    = 32;
    localparam int unsigned WBQ_PTR_W = $clog2(WBQ_DEPTH);

    typedef struct packed {
        logic [WBQ_AW-1:0] addr;
        logic [WBQ_DW-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/wb_write_queue_match.sv
// Youngest-match forwarding lookup over the write queue.
// Ports:
//   occ      - per-slot occupancy mask
//   addrs    - stored destination addresses, one per slot
//   datas    - stored write data, one per slot
//   tail     - next slot to be written (the youngest entry sits at tail-1)
//   q_addr   - lookup address
//   hit      - some occupied slot targets q_addr
//   hit_data - data of the youngest matching slot, 0 when no hit
// Purely combinational.
module wbq_match
    import wb_write_queue_pkg::*;
#(
    parameter int unsigned DEPTH = WBQ_DEPTH,
    parameter int unsigned AW    = WBQ_AW,
    parameter int unsigned DW    = WBQ_DW
) (
    input  logic [DEPTH-1:0]               occ,
    input  logic [DEPTH-1:0][AW-1:0]       addrs,
    input  logic [DEPTH-1:0][DW-1:0]       datas,
    input  logic [$clog2(DEPTH)-1:0]       tail,
    input  logic [AW-1:0]                  q_addr,
    output logic                           hit,
    output logic [DW-1:0]                  hit_data
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk slots from oldest (tail-DEPTH) to youngest (tail-1); a later
    // match overrides an earlier one, so the youngest match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int unsigned k = DEPTH; k >= 1; k--) begin
            idx = tail - PW'(k);
            if (occ[idx] && (addrs[idx] == q_addr)) begin
                hit      = 1'b1;
                hit_data = datas[idx];
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// Register-file write-back queue with address-based forwarding.
// Ports:
//   clk, Reset               - clock, synchronous active-high reset
//   In_Valid/In_Ready        - upstream write request handshake
//   In_Addr/In_Data          - request register number and value
//   Drain_En                 - allows the head entry to be written back
//   Write_Reg/W_Addr/W_Data  - register-file write port (head entry)
//   Q_Addr/Q_Hit/Q_Data      - forwarding lookup of youngest queued write
//   Count/Empty/Full         - registered occupancy status
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int unsigned DEPTH = WBQ_DEPTH,
    parameter int unsigned AW    = WBQ_AW,
    parameter int unsigned DW    = WBQ_DW
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic [AW-1:0]            In_Addr,
    input  logic [DW-1:0]            In_Data,
    input  logic                     Drain_En,
    output logic                     Write_Reg,
    output logic [AW-1:0]            W_Addr,
    output logic [DW-1:0]            W_Data,
    input  logic [AW-1:0]            Q_Addr,
    output logic                     Q_Hit,
    output logic [DW-1:0]            Q_Data,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Empty,
    output logic                     Full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;
    logic [CW-1:0]            count;
    logic [DEPTH-1:0]         occ;
    logic [PW-1:0]            off;
    logic                     push;
    logic                     pop;

    assign Empty     = (count == '0);
    assign Full      = (count == CW'(DEPTH));
    assign In_Ready  = !Full;
    assign Write_Reg = !Empty && Drain_En;
    assign W_Addr    = addr_q[head];
    assign W_Data    = data_q[head];
    assign Count     = count;

    // A full queue refuses pushes even if the head drains this same edge.
    assign push = In_Valid && !Full;
    assign pop  = Write_Reg;

    always_ff @(posedge clk) begin
        if (Reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (push) begin
                addr_q[tail] <= In_Addr;
                data_q[tail] <= In_Data;
                tail         <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // A slot is occupied when its distance from head is below count; the
    // PW-bit subtraction wraps naturally because DEPTH is a power of two.
    always_comb begin
        occ = '0;
        off = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off    = PW'(i) - head;
            occ[i] = ({1'b0, off} < count);
        end
    end

    wbq_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_match (
        .occ      (occ),
        .addrs    (addr_q),
        .datas    (data_q),
        .tail     (tail),
        .q_addr   (Q_Addr),
        .hit      (Q_Hit),
        .hit_data (Q_Data)
    );

endmodule
